// File: rtl/arith_pkg.sv
// Shared arithmetic types and helpers for the borrow-lookahead subtractor datapath.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package arith_pkg;

    localparam int SLICE_W = 4;

    // Per-bit borrow generate/propagate for one lookahead slice.
    typedef struct packed {
        logic [SLICE_W-1:0] g;
        logic [SLICE_W-1:0] p;
    } gp_t;

    // Resolved slice: four difference bits plus the borrow leaving the slice.
    typedef struct packed {
        logic [SLICE_W-1:0] diff;
        logic               bout;
    } slice_t;

    // Borrow is generated when a=0,b=1; an incoming borrow passes through when a==b.
    function automatic gp_t borrow_gp(input logic [SLICE_W-1:0] a,
                                      input logic [SLICE_W-1:0] b);
        gp_t r;
        r.g = ~a & b;
        r.p = ~(a ^ b);
        return r;
    endfunction

endpackage

// File: rtl/pipelined_bla_subtractor_if.sv
// Operand/result stream bundle between producer, subtractor and consumer.
// Latency: none (wires only).
// Backpressure: valid/ready on both the operand side and the result side.
interface pipelined_bla_subtractor_if #(
    parameter int WIDTH = 16
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    // Producer/consumer side: drives operands and result-ready.
    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf
    );

    // Subtractor side.
    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf
    );

endinterface

// File: rtl/borrow_lookahead_slice_4.sv
// 4-bit borrow-lookahead slice: diff = a - b - bin, bout = borrow leaving bit 3.
// Latency: purely combinational.
// Backpressure: none; the enclosing pipeline stage decides when results are captured.
module borrow_lookahead_slice_4
    import arith_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               bin,
    output logic [SLICE_W-1:0] diff,
    output logic               bout
);

    gp_t              gp;
    logic [SLICE_W:0] bw;

    assign gp = borrow_gp(a, b);

    // Flattened lookahead: every internal borrow is two gate levels from g/p/bin.
    assign bw[0] = bin;
    assign bw[1] = gp.g[0] | (gp.p[0] & bin);
    assign bw[2] = gp.g[1] | (gp.p[1] & gp.g[0]) | (gp.p[1] & gp.p[0] & bin);
    assign bw[3] = gp.g[2] | (gp.p[2] & gp.g[1]) | (gp.p[2] & gp.p[1] & gp.g[0])
                 | (gp.p[2] & gp.p[1] & gp.p[0] & bin);
    assign bw[4] = gp.g[3] | (gp.p[3] & gp.g[2]) | (gp.p[3] & gp.p[2] & gp.g[1])
                 | (gp.p[3] & gp.p[2] & gp.p[1] & gp.g[0])
                 | (gp.p[3] & gp.p[2] & gp.p[1] & gp.p[0] & bin);

    assign diff = a ^ b ^ bw[SLICE_W-1:0];
    assign bout = bw[SLICE_W];

endmodule

// File: rtl/pipelined_bla_subtractor.sv
// Pipelined a - b - bin: one 4-bit borrow-lookahead slice per registered stage.
// Latency: NSTAGE register stages; full throughput of one result per cycle.
// Backpressure: bubble-collapsing; a stage loads when empty or when it drains the same cycle.
module pipelined_bla_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input logic                        clk,
    input logic                        rst_n,
    pipelined_bla_subtractor_if.slave  io
);

    localparam int NSTAGE = WIDTH / SLICE;

    // Stage registers: valid bit, operands still to be resolved, partial diff, ripple borrow.
    logic [NSTAGE-1:0]            vld_q;
    logic [NSTAGE-1:0][WIDTH-1:0] a_q;
    logic [NSTAGE-1:0][WIDTH-1:0] b_q;
    logic [NSTAGE-1:0][WIDTH-1:0] dif_q;
    logic [NSTAGE-1:0]            bw_q;

    // What each stage would capture: the previous stage's register, or the input port.
    logic [NSTAGE-1:0]            src_vld;
    logic [NSTAGE-1:0][WIDTH-1:0] src_a;
    logic [NSTAGE-1:0][WIDTH-1:0] src_b;
    logic [NSTAGE-1:0][WIDTH-1:0] src_d;
    logic [NSTAGE-1:0]            src_bw;
    slice_t [NSTAGE-1:0]          res;
    logic [NSTAGE-1:0]            take;

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign src_vld[k] = io.in_valid;
            assign src_a[k]   = io.a;
            assign src_b[k]   = io.b;
            assign src_d[k]   = '0;
            assign src_bw[k]  = io.bin;
        end else begin : g_body
            assign src_vld[k] = vld_q[k-1];
            assign src_a[k]   = a_q[k-1];
            assign src_b[k]   = b_q[k-1];
            assign src_d[k]   = dif_q[k-1];
            assign src_bw[k]  = bw_q[k-1];
        end

        borrow_lookahead_slice_4 u_slice (
            .a    (src_a[k][SLICE*k +: SLICE]),
            .b    (src_b[k][SLICE*k +: SLICE]),
            .bin  (src_bw[k]),
            .diff (res[k].diff),
            .bout (res[k].bout)
        );
    end

    // Ready ripples back from the consumer: a stage can take new content if it is empty or moving on.
    always_comb begin
        take = '0;
        take[NSTAGE-1] = !vld_q[NSTAGE-1] || io.out_ready;
        for (int k = NSTAGE - 2; k >= 0; k--) begin
            take[k] = !vld_q[k] || take[k+1];
        end
    end

    // Valid bits: the only state that needs reset; clearing them discards everything in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            for (int k = 0; k < NSTAGE; k++) begin
                if (take[k]) begin
                    vld_q[k] <= src_vld[k];
                end
            end
        end
    end

    // Datapath capture: resolve this stage's slice and merge it into the running diff.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NSTAGE; k++) begin
            if (take[k] && src_vld[k]) begin
                a_q[k]   <= src_a[k];
                b_q[k]   <= src_b[k];
                bw_q[k]  <= res[k].bout;
                dif_q[k] <= src_d[k] | (WIDTH'(res[k].diff) << (SLICE * k));
            end
        end
    end

    // Only the sign bits of the last stage's operands matter (for overflow).
    logic unused_lo;
    assign unused_lo = ^{a_q[NSTAGE-1][WIDTH-2:0], b_q[NSTAGE-1][WIDTH-2:0]};

    // Outputs are gated by valid so they read zero whenever nothing is presented.
    assign io.in_ready  = take[0];
    assign io.out_valid = vld_q[NSTAGE-1];
    assign io.diff      = vld_q[NSTAGE-1] ? dif_q[NSTAGE-1] : '0;
    assign io.bout      = vld_q[NSTAGE-1] & bw_q[NSTAGE-1];
    assign io.ovf       = vld_q[NSTAGE-1]
                        & (a_q[NSTAGE-1][WIDTH-1] ^ b_q[NSTAGE-1][WIDTH-1])
                        & (dif_q[NSTAGE-1][WIDTH-1] ^ a_q[NSTAGE-1][WIDTH-1]);

endmodule
